bcd_sig_formatter: RTL
======================

// Module: bcd_sig_formatter
// PURPOSE
//  Sequential binary-to-BCD converter and normaliser for the frequency counter.
//  Converts a binary reading into 4 significant BCD digits plus a decimal exponent oDEC.
//  Output satisfies: display value x 10^oDEC ~= input.
//  Sits between the measurement/division stage and the four bin2sseg digit decoders.
//  oDEC drives the range LEDs.
// PARAMETERS
//  W       20  input width in bits; 4 <= W <= 26
//  DIGITS  7   BCD digits produced by conversion; need 10^DIGITS > 2^W; DIGITS <= 8
// PORTS
//  iCLK     in   1   system clock; all logic on rising edge
//  iRESET   in   1   synchronous, active-high reset
//  iSTART   in   1   start pulse; iBIN sampled when iSTART && oREADY
//  iBIN     in   W   unsigned binary reading
//  oREADY   out  1   high in IDLE only
//  oDONE    out  1   one-cycle pulse; result outputs updated on the same edge
//  oBCD3    out  4   most significant displayed digit
//  oBCD2    out  4   displayed digit
//  oBCD1    out  4   displayed digit
//  oBCD0    out  4   least significant displayed digit
//  oDEC     out  2   exponent e: digits dropped from the right, 0..3
//  oOVF     out  1   value not representable as 4 digits with e<=3; display saturated
// BEHAVIOUR
//  Reset:
//   - state IDLE; oREADY=1; oDONE=0
//   - all oBCD*=0; oDEC=0; oOVF=0
//  Reset mid-operation: conversion aborted, no oDONE, outputs to reset values.
//  FSM states: IDLE -> CONV -> NORM -> [ROUND] -> DONE -> IDLE
//   - IDLE: on iSTART, load iBIN into shift register, clear BCD register and e; go to CONV.
//   - CONV: double-dabble, exactly W cycles.
//     Each cycle: add 3 to every BCD digit >= 5, then shift left one bit.
//   - NORM: each cycle, if any digit above position e+3 is nonzero and e<3:
//     shift the BCD register right one digit, keep the dropped digit as rdig, e++.
//     Otherwise exit. Takes k+1 cycles, where k = number of shifts (0..3).
//   - ROUND (ROUND_EN only): 1 cycle, see CONFIGURATION.
//   - DONE: 1 cycle; oDONE=1; outputs registered on entry; then back to IDLE.
//  Latency: iSTART sampled at edge t -> oDONE high after edge t+W+k+1 (+1 with ROUND_EN).
//  Overflow: digits above position e+3 still nonzero after NORM at e=3:
//   - oBCD=9999, oDEC=3, oOVF=1
//  iSTART while not in IDLE: ignored. iBIN changes after sampling: no effect.
//  Results hold until the next DONE. Back-to-back: iSTART may be accepted the cycle after DONE.
//  Leading zeros are not blanked: 0x7 -> 0007, e=0.
// CONFIGURATION
//  Macro BCD_SIG_FORMATTER_ROUND_EN
//  Defined: ROUND state rounds half-up using rdig (the last digit dropped).
//   - rdig >= 5 and e > 0: increment the 4-digit BCD value.
//   - Carry out to 10000 with e<3: result 1000, e+1.
//   - Carry out to 10000 with e=3: saturate to 9999, oOVF=1.
//  Undefined: truncation; ROUND state absent; latency one cycle shorter.
// STRUCTURE
//  Header bcd_sig_formatter_defs.vh, shared with the other display-path blocks:
//   - state encodings (IDLE, CONV, NORM, ROUND, DONE)
//   - BCD digit width 4; max exponent 3; saturation digit 4'd9
//  Sub-module bcd_inc4: combinational 4-digit BCD +1 with carry out.
//   - Used by ROUND only; instantiated under the macro.
// TESTING
//  T1 iBIN=0 -> 0000, e=0, oOVF=0; oDONE after edge t+W+1 (+1 with ROUND_EN).
//  T2 iBIN=1234 -> 1234, e=0.
//  T3 iBIN=12345 -> 1234 e=1 (trunc); 1235 e=1 (ROUND_EN).
//  T4 iBIN=999999 -> 9999 e=2 (trunc); 1000 e=3 (ROUND_EN, carry renormalise).
//  T5 iBIN=1048575 -> 1048 e=3 (trunc); 1049 e=3 (ROUND_EN).
//  T5 with W=24, DIGITS=8: iBIN=12345678 -> 9999 e=3, oOVF=1.
//  T6 iSTART every cycle during CONV -> single oDONE, result of the first sample.
//  T6 iRESET at CONV cycle 5 -> no oDONE; outputs zero; oREADY=1 the next cycle.

Source files
------------

// File: rtl/bcd_sig_formatter_pkg.sv
// Shared definitions for the frequency-counter display path:
// FSM state encodings, BCD digit geometry, saturation constants and
// the double-dabble digit adjust helper.
package bcd_sig_formatter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CONV  = 3'd1,
      ST_NORM  = 3'd2,
      ST_ROUND = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int         DIGIT_W   = 4;
   localparam logic [1:0] MAX_EXP   = 2'd3;
   localparam logic [3:0] SAT_DIGIT = 4'd9;

   // Double-dabble correction: a digit of 5 or more would exceed 9 after
   // the next shift, so pre-bias it by 3.
   function automatic logic [3:0] dd_adj(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

endpackage

// File: rtl/bcd_sig_formatter_inc4.sv
// bcd_inc4: combinational +1 on a 4-digit packed BCD value with carry out.
// Carry out is set only for 9999 -> 0000.
module bcd_inc4 (
   input  logic [15:0] bcd,
   output logic [15:0] sum,
   output logic        co
);

   // Ripple the increment digit by digit; a 9 with carry-in wraps to 0.
   always_comb begin
      logic c;
      c   = 1'b1;
      sum = '0;
      for (int i = 0; i < 4; i++) begin
         if (c && bcd[i*4 +: 4] == 4'd9) begin
            sum[i*4 +: 4] = 4'd0;
         end else begin
            sum[i*4 +: 4] = bcd[i*4 +: 4] + {3'b000, c};
            c             = 1'b0;
         end
      end
      co = c;
   end

endmodule

// File: rtl/bcd_sig_formatter.sv
// bcd_sig_formatter: sequential binary-to-BCD converter that keeps the four
// most significant decimal digits and reports how many were dropped (oDEC).
// Optional half-up rounding of the dropped digit: BCD_SIG_FORMATTER_ROUND_EN.
module bcd_sig_formatter
   import bcd_sig_formatter_pkg::*;
#(
   parameter int W      = 20,
   parameter int DIGITS = 7
) (
   input  logic         iCLK,
   input  logic         iRESET,
   input  logic         iSTART,
   input  logic [W-1:0] iBIN,
   output logic         oREADY,
   output logic         oDONE,
   output logic [3:0]   oBCD3,
   output logic [3:0]   oBCD2,
   output logic [3:0]   oBCD1,
   output logic [3:0]   oBCD0,
   output logic [1:0]   oDEC,
   output logic         oOVF
);

   localparam int BW = DIGITS * DIGIT_W;
   localparam int CW = $clog2(W + 1);

   state_t          state, state_nxt;
   logic [W-1:0]    bin_sr;
   logic [BW-1:0]   bcd, bcd_adj;
   logic [CW-1:0]   cnt;
   logic [1:0]      e;
   logic [31:0]     bcd_ext;
   logic [15:0]     lo4;
   logic            upper_nz, can_shift;
   logic [15:0]     res_bcd, bcd_q;
   logic [1:0]      res_dec;
   logic            res_ovf;

   // Zero-extended view so the "above the four displayed digits" test
   // works for any DIGITS up to 8.
   assign bcd_ext   = 32'(bcd);
   assign lo4       = bcd_ext[15:0];
   assign upper_nz  = |bcd_ext[31:16];
   assign can_shift = upper_nz && (e != MAX_EXP);

`ifdef BCD_SIG_FORMATTER_ROUND_EN
   logic [3:0]  rdig;
   logic [15:0] inc_sum;
   logic        inc_co;

   bcd_inc4 u_inc (
      .bcd (lo4),
      .sum (inc_sum),
      .co  (inc_co)
   );
`endif

   // Per-digit add-3 correction ahead of each conversion shift.
   always_comb begin
      bcd_adj = '0;
      for (int i = 0; i < DIGITS; i++)
         bcd_adj[i*4 +: 4] = dd_adj(bcd[i*4 +: 4]);
   end

   // State register.
   always_ff @(posedge iCLK) begin
      if (iRESET) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (iSTART) state_nxt = ST_CONV;
         ST_CONV: if (cnt == CW'(W - 1)) state_nxt = ST_NORM;
`ifdef BCD_SIG_FORMATTER_ROUND_EN
         ST_NORM:  if (!can_shift) state_nxt = ST_ROUND;
         ST_ROUND: state_nxt = ST_DONE;
`else
         ST_NORM:  if (!can_shift) state_nxt = ST_DONE;
`endif
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Final display value: saturate if still too wide at e=3, else
   // truncate (or round half-up on the last dropped digit).
   always_comb begin
      res_bcd = lo4;
      res_dec = e;
      res_ovf = 1'b0;
      if (upper_nz) begin
         res_bcd = {SAT_DIGIT, SAT_DIGIT, SAT_DIGIT, SAT_DIGIT};
         res_dec = MAX_EXP;
         res_ovf = 1'b1;
      end
`ifdef BCD_SIG_FORMATTER_ROUND_EN
      else if (rdig >= 4'd5 && e != 2'd0) begin
         if (!inc_co) begin
            res_bcd = inc_sum;
         end else if (e != MAX_EXP) begin
            res_bcd = 16'h1000;
            res_dec = e + 2'd1;
         end else begin
            res_bcd = {SAT_DIGIT, SAT_DIGIT, SAT_DIGIT, SAT_DIGIT};
            res_ovf = 1'b1;
         end
      end
`endif
   end

   // Conversion datapath and result registers; results load on DONE entry.
   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         bin_sr <= '0;
         bcd    <= '0;
         cnt    <= '0;
         e      <= '0;
         bcd_q  <= '0;
         oDEC   <= '0;
         oOVF   <= 1'b0;
`ifdef BCD_SIG_FORMATTER_ROUND_EN
         rdig   <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: if (iSTART) begin
               bin_sr <= iBIN;
               bcd    <= '0;
               cnt    <= '0;
               e      <= '0;
`ifdef BCD_SIG_FORMATTER_ROUND_EN
               rdig   <= '0;
`endif
            end
            ST_CONV: begin
               bcd    <= {bcd_adj[BW-2:0], bin_sr[W-1]};
               bin_sr <= {bin_sr[W-2:0], 1'b0};
               cnt    <= cnt + CW'(1);
            end
            ST_NORM: if (can_shift) begin
               bcd <= bcd >> 4;
               e   <= e + 2'd1;
`ifdef BCD_SIG_FORMATTER_ROUND_EN
               rdig <= bcd[3:0];
`endif
            end
            default: ;
         endcase
         if (state_nxt == ST_DONE) begin
            bcd_q <= res_bcd;
            oDEC  <= res_dec;
            oOVF  <= res_ovf;
         end
      end
   end

   assign oREADY = (state == ST_IDLE);
   assign oDONE  = (state == ST_DONE);
   assign oBCD3  = bcd_q[15:12];
   assign oBCD2  = bcd_q[11:8];
   assign oBCD1  = bcd_q[7:4];
   assign oBCD0  = bcd_q[3:0];

endmodule
